// File: rtl/seg7_pkg.sv
// Shared glyph constants, FSM state type and the pattern-to-code mapping
// for the 7-segment encoder.
package seg7_pkg;

    // Segment patterns are written abcdefg; bit [0] is segment a.
    localparam logic [0:6] SEG_0     = 7'b1111110;
    localparam logic [0:6] SEG_1     = 7'b0110000;
    localparam logic [0:6] SEG_2     = 7'b1101101;
    localparam logic [0:6] SEG_3     = 7'b1111001;
    localparam logic [0:6] SEG_4     = 7'b0110011;
    localparam logic [0:6] SEG_5     = 7'b1011011;
    localparam logic [0:6] SEG_6     = 7'b1011111;
    localparam logic [0:6] SEG_7     = 7'b1110000;
    localparam logic [0:6] SEG_8     = 7'b1111111;
    localparam logic [0:6] SEG_9     = 7'b1111011;
    localparam logic [0:6] SEG_A     = 7'b1110111;
    localparam logic [0:6] SEG_B     = 7'b0011111;
    localparam logic [0:6] SEG_C     = 7'b1001110;
    localparam logic [0:6] SEG_D     = 7'b0111101;
    localparam logic [0:6] SEG_E     = 7'b1001111;
    localparam logic [0:6] SEG_F     = 7'b1000111;
    localparam logic [0:6] SEG_BLANK = 7'b0000000;

    localparam logic [0:4] COD_BLANK = 5'b11111;
    localparam logic [0:4] COD_ERRO  = 5'b00000;

    typedef enum logic [1:0] {
        ESPERA,
        VALIDO,
        RECUPERA
    } estado_t;

    // Returns {erro, codigo}; unrecognised patterns report erro with code 0.
    function automatic logic [5:0] codifica(input logic [0:6] seg);
        logic [5:0] r;
        case (seg)
            SEG_0:     r = {1'b0, 5'h00};
            SEG_1:     r = {1'b0, 5'h01};
            SEG_2:     r = {1'b0, 5'h02};
            SEG_3:     r = {1'b0, 5'h03};
            SEG_4:     r = {1'b0, 5'h04};
            SEG_5:     r = {1'b0, 5'h05};
            SEG_6:     r = {1'b0, 5'h06};
            SEG_7:     r = {1'b0, 5'h07};
            SEG_8:     r = {1'b0, 5'h08};
            SEG_9:     r = {1'b0, 5'h09};
            SEG_A:     r = {1'b0, 5'h0A};
            SEG_B:     r = {1'b0, 5'h0B};
            SEG_C:     r = {1'b0, 5'h0C};
            SEG_D:     r = {1'b0, 5'h0D};
            SEG_E:     r = {1'b0, 5'h0E};
            SEG_F:     r = {1'b0, 5'h0F};
            SEG_BLANK: r = {1'b0, COD_BLANK};
            default:   r = {1'b1, COD_ERRO};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_codificador_if.sv
// Result handshake of the encoder: code plus error flag, qualified by valida,
// accepted by pronto.
interface seg7_codificador_if;
    import seg7_pkg::*;

    logic [0:4] codigo;
    logic       erro;
    logic       valida;
    logic       pronto;

    modport master (
        output codigo,
        output erro,
        output valida,
        input  pronto
    );

    modport slave (
        input  codigo,
        input  erro,
        input  valida,
        output pronto
    );
endinterface

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous lines.
module sincronizador_2ff #(
    parameter int LARGURA = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);
    logic [LARGURA-1:0] s1_reg;
    logic [LARGURA-1:0] s2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= d;
            s2_reg <= s1_reg;
        end
    end

    assign q = s2_reg;
endmodule

// File: rtl/seg7_codificador.sv
// Debounces a 7-segment pattern bus and emits each newly stabilised glyph as
// its 5-bit code over a valid/ready handshake.
module seg7_codificador
    import seg7_pkg::*;
#(
    parameter int ESTAVEL_CICLOS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [0:6]             segmentos,
    seg7_codificador_if.master     bus
);
    localparam logic [3:0] ALVO = 4'(ESTAVEL_CICLOS);

    logic [0:6] s2;
    logic [0:6] s2_prev_reg;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;
    logic [0:6] ultimo_reg;
    logic       tem_ultimo_reg;
    logic [0:4] codigo_reg;
    logic       erro_reg;
    logic       evento;
    logic       carga;
    logic [5:0] cod_s2;
    estado_t    state_reg;
    estado_t    state_next;

    sincronizador_2ff #(.LARGURA(7)) u_sinc (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (segmentos),
        .q     (s2)
    );

    // cnt_next is the stability count of the current s2 value: zero in the
    // cycle it changes, so a clean change is accepted ESTAVEL_CICLOS cycles later.
    always_comb begin
        cnt_next = cnt_reg;
        if (s2 != s2_prev_reg)
            cnt_next = 4'd0;
        else if (cnt_reg != ALVO)
            cnt_next = cnt_reg + 4'd1;
    end

    assign evento = (cnt_next == ALVO) && (!tem_ultimo_reg || (s2 != ultimo_reg));
    assign cod_s2 = codifica(s2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_prev_reg <= '0;
            cnt_reg     <= '0;
        end else begin
            s2_prev_reg <= s2;
            cnt_reg     <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ESPERA;
        else
            state_reg <= state_next;
    end

    // A pending event during RECUPERA loads directly, keeping the gap to one cycle.
    always_comb begin
        state_next = state_reg;
        carga      = 1'b0;
        case (state_reg)
            ESPERA: begin
                if (evento) begin
                    carga      = 1'b1;
                    state_next = VALIDO;
                end
            end
            VALIDO: begin
                if (bus.pronto)
                    state_next = RECUPERA;
            end
            RECUPERA: begin
                if (evento) begin
                    carga      = 1'b1;
                    state_next = VALIDO;
                end else begin
                    state_next = ESPERA;
                end
            end
            default: state_next = ESPERA;
        endcase
    end

    always_comb begin
        bus.valida = (state_reg == VALIDO);
        bus.codigo = codigo_reg;
        bus.erro   = erro_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            codigo_reg     <= '0;
            erro_reg       <= 1'b0;
            ultimo_reg     <= '0;
            tem_ultimo_reg <= 1'b0;
        end else if (carga) begin
            erro_reg       <= cod_s2[5];
            codigo_reg     <= cod_s2[4:0];
            ultimo_reg     <= s2;
            tem_ultimo_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seg7_codificador.sv
// Directed bench for seg7_codificador: glyph table sweep plus handshake,
// glitch and reset corner sequences.
module tb_seg7_codificador;
    import seg7_pkg::*;

    localparam int EST = 4;
    localparam int LAT = EST + 3; // negedge samples after the input is driven

    typedef struct {
        logic [0:6] seg;
        logic [0:4] cod;
        logic       erro;
    } vetor_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:6] segmentos = 7'b0000000;

    int n_checks = 0;
    int n_pass   = 0;

    seg7_codificador_if bus_if ();

    seg7_codificador #(.ESTAVEL_CICLOS(EST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .segmentos (segmentos),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string nome, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
            $display("ok   %s: %0d", nome, act);
        end else begin
            $display("FAIL %s: got %0d expected %0d", nome, act, exp);
        end
    endtask

    // Waits for valida, returning the sample index at which it appeared or -1.
    task automatic wait_valida(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus_if.valida) begin
                lat = i;
                break;
            end
        end
    endtask

    // Holds the current input for n cycles, counting valida samples.
    task automatic hold(input int n, output int pulses, output int cod, output int err);
        pulses = 0;
        cod    = -1;
        err    = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus_if.valida) begin
                pulses++;
                cod = int'(bus_if.codigo);
                err = int'(bus_if.erro);
            end
        end
    endtask

    vetor_t tab [19];
    int lat, pulses, cod, err, bad, p2;

    initial begin
        tab[0]  = '{SEG_1, 5'h01, 1'b0};
        tab[1]  = '{SEG_2, 5'h02, 1'b0};
        tab[2]  = '{SEG_3, 5'h03, 1'b0};
        tab[3]  = '{SEG_4, 5'h04, 1'b0};
        tab[4]  = '{SEG_5, 5'h05, 1'b0};
        tab[5]  = '{SEG_6, 5'h06, 1'b0};
        tab[6]  = '{SEG_7, 5'h07, 1'b0};
        tab[7]  = '{SEG_8, 5'h08, 1'b0};
        tab[8]  = '{SEG_9, 5'h09, 1'b0};
        tab[9]  = '{SEG_A, 5'h0A, 1'b0};
        tab[10] = '{SEG_B, 5'h0B, 1'b0};
        tab[11] = '{SEG_C, 5'h0C, 1'b0};
        tab[12] = '{SEG_D, 5'h0D, 1'b0};
        tab[13] = '{SEG_E, 5'h0E, 1'b0};
        tab[14] = '{SEG_F, 5'h0F, 1'b0};
        tab[15] = '{SEG_BLANK, 5'b11111, 1'b0};
        tab[16] = '{SEG_0, 5'h00, 1'b0};
        tab[17] = '{7'b1010101, 5'b00000, 1'b1};
        tab[18] = '{7'b0000001, 5'b00000, 1'b1};

        bus_if.pronto = 1'b1;
        #12;
        check("reset valida", int'(bus_if.valida), 0);
        check("reset codigo", int'(bus_if.codigo), 0);
        check("reset erro", int'(bus_if.erro), 0);

        // 1: first glyph after reset, exact latency and a single pulse
        @(negedge clk);
        rst_n = 1'b1;
        segmentos = SEG_0;
        wait_valida(20, lat);
        check("t1 latency", lat, LAT);
        check("t1 codigo", int'(bus_if.codigo), 0);
        check("t1 erro", int'(bus_if.erro), 0);
        hold(20, pulses, cod, err);
        check("t1 no repeat", pulses, 0);

        // 2/3: table sweep, one emission per entry
        for (int k = 0; k < 19; k++) begin
            segmentos = tab[k].seg;
            hold(10, pulses, cod, err);
            check($sformatf("vec%0d pulses", k), pulses, 1);
            check($sformatf("vec%0d codigo", k), cod, int'(tab[k].cod));
            check($sformatf("vec%0d erro", k), err, int'(tab[k].erro));
        end

        // 4: glitch away from and back to the last emitted glyph
        segmentos = SEG_0;
        hold(10, pulses, cod, err);
        check("t4 settle pulses", pulses, 1);
        check("t4 settle codigo", cod, 0);
        segmentos = SEG_1;
        hold(2, pulses, cod, err);
        segmentos = SEG_0;
        hold(15, p2, cod, err);
        check("t4 glitch pulses", pulses + p2, 0);

        // 5: held result under back-pressure, then the pending glyph
        bus_if.pronto = 1'b0;
        segmentos = SEG_3;
        wait_valida(20, lat);
        check("t5 latency", lat, LAT);
        check("t5 codigo", int'(bus_if.codigo), 3);
        segmentos = SEG_7;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus_if.valida || bus_if.codigo != 5'h03) bad++;
        end
        check("t5 held samples bad", bad, 0);
        bus_if.pronto = 1'b1;
        @(negedge clk);
        check("t5 gap valida", int'(bus_if.valida), 0);
        @(negedge clk);
        check("t5 second valida", int'(bus_if.valida), 1);
        check("t5 second codigo", int'(bus_if.codigo), 7);
        @(negedge clk);
        check("t5 after accept valida", int'(bus_if.valida), 0);

        // 6: asynchronous reset mid-handshake, then re-emission
        bus_if.pronto = 1'b0;
        segmentos = SEG_9;
        wait_valida(20, lat);
        check("t6 latency", lat, LAT);
        check("t6 codigo", int'(bus_if.codigo), 9);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 async valida", int'(bus_if.valida), 0);
        check("t6 async codigo", int'(bus_if.codigo), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valida(20, lat);
        check("t6 re-emit latency", lat, LAT);
        check("t6 re-emit codigo", int'(bus_if.codigo), 9);
        check("t6 re-emit erro", int'(bus_if.erro), 0);
        bus_if.pronto = 1'b1;
        hold(3, pulses, cod, err);
        check("t6 accepted pulses", pulses, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seg7_codificador.md
Name: seg7_codificador

Overview:
Reverse direction of the 5-bit-to-7-segment decoder: samples a 7-segment pattern bus from a display harness or decoder output, and debounces it. It then encodes each newly stabilised glyph back to its 5-bit code and emits it through a valid/ready handshake. It is used for loop-back checking of the decoder and for reading back panel segment lines.

Parameters:
ESTAVEL_CICLOS, 4, consecutive synchronised cycles a pattern must hold before it is accepted (legal range 1..15).

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
segmentos  input  [0:6]  segment lines, active-high; [0]=a, [1]=b ... [6]=g
codigo  output  [0:4]  encoded glyph; [0] is the MSB
erro  output  1  qualifies codigo: 1 means the pattern is not a legal glyph
valida  output  1  codigo/erro hold a new result
pronto  input  1  consumer accepts the result when valida && pronto at a rising edge

Behaviour:
- Reset (rst_n=0, asynchronous) sets the following: valida=0, codigo=5'b00000, erro=0, sync flops=0, stability counter=0, tem_ultimo=0, ultimo=7'b0000000, state ESPERA.
- Input path: segmentos passes through a 2-flop synchroniser (s1→s2). Only s2 is used downstream.
- Stability counter cnt (4 bits): cleared to 0 when s2 differs from its previous-cycle value; otherwise increments, saturating at ESTAVEL_CICLOS.
- Stable event: cnt==ESTAVEL_CICLOS and (tem_ultimo==0 or s2!=ultimo).
- Latency: for a clean change, valida rises exactly ESTAVEL_CICLOS+2 rising edges after the first edge at which s1 captures the new value.
- Encoding uses a fixed table, with literals written abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111 → codes 5'h00..5'h0F, erro=0
  - blank 0000000 → 5'b11111, erro=0
  - any other pattern → codigo=5'b00000, erro=1
- FSM states:
  - ESPERA: on a stable event, register codigo/erro, load ultimo=s2, set tem_ultimo=1, assert valida → VALIDO.
  - VALIDO: valida=1; codigo/erro frozen while pronto=0. On valida&&pronto → valida=0 → RECUPERA.
  - RECUPERA: exactly one cycle with valida=0 → ESPERA. A stable event pending at this point is emitted on the following cycle.
- Input changes while in VALIDO do not alter the held result. The counter keeps running, and after RECUPERA the current s2 is compared against ultimo.
- Glitches shorter than ESTAVEL_CICLOS cycles are never emitted.
- A pattern that leaves and returns to ultimo without stabilising elsewhere produces no emission.
- Back-to-back identical stable patterns produce one emission only.
- Reset asserted mid-handshake clears valida immediately. After release, the first stable pattern (including the one present at release) is emitted, because tem_ultimo=0.

Decomposition:
- seg7_pkg:
  - SEG_* glyph constants for the 16 hex patterns and SEG_BLANK
  - COD_BLANK=5'b11111 and COD_ERRO=5'b00000
  - state enum {ESPERA, VALIDO, RECUPERA}
  - pure function that maps a 7-bit pattern to {erro, codigo}
- Sub-module: sincronizador_2ff (parameterised width), instantiated at width 7 for segmentos.

Test Plan:
1. Reset, then hold segmentos=1111110 with pronto=1 → valida pulses for one cycle exactly 6 edges after capture, codigo=5'b00000, erro=0; no further pulse while the input is held.
2. Sweep all 16 hex glyphs plus blank, each held 10 cycles, pronto=1 → codigo 5'h00..5'h0F then 5'b11111, erro=0, one valida per glyph.
3. segmentos=1010101 held 10 cycles → valida=1, codigo=5'b00000, erro=1.
4. 1111110 stable, then 0110000 for 2 cycles, then back to 1111110 → exactly one emission (code 0); the glitch is never emitted.
5. pronto=0 with glyph 3 stable, then switch to glyph 7 for 10 cycles; raise pronto later → code 5'h03 held unchanged until accepted, valida low for one cycle, then code 5'h07 emitted.
6. Assert rst_n=0 while valida=1 with the input held at glyph 9 → valida drops asynchronously. After release, code 5'h09 is re-emitted after ESTAVEL_CICLOS+2 edges.
